// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive controller.
//   ctrl_state_e : controller FSM state encoding (OFF/INIT/ARMED/RECOVER)
//   BYTE_W       : width of one received byte
//   CNT_W        : width of the FIFO occupancy output
package uart_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_INIT    = 2'd1,
        ST_ARMED   = 2'd2,
        ST_RECOVER = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: link between a UART receiver and its controller.
//   rx_data/rx_done/rx_busy/rx_err : receiver -> controller status
//   rx_en/rx_start                 : controller -> receiver control
// Modports: master = receiver side, slave = controller side.
interface uart_rx_ctrl_if;
    import uart_pkg::*;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_done;
    logic              rx_busy;
    logic              rx_err;
    logic              rx_en;
    logic              rx_start;

    modport master (
        output rx_data, rx_done, rx_busy, rx_err,
        input  rx_en, rx_start
    );

    modport slave (
        input  rx_data, rx_done, rx_busy, rx_err,
        output rx_en, rx_start
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock show-ahead FIFO.
//   push/wr_data : write request (ignored when full unless popping the same edge)
//   pop          : read request (ignored when empty)
//   rd_data      : head entry, valid while !empty
//   full/empty/count : occupancy derived from registered state
module uart_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the same edge frees a slot.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is reset so the head reads 0 until the first write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequences a UART receiver and buffers its bytes.
//   rx_clk/rx_rst_n : clock, async active-low reset
//   ctrl_en         : enables reception (0 forces OFF, FIFO kept)
//   rx_if (slave)   : receiver status in, rx_en/rx_start out (registered)
//   rd_en/rd_data/fifo_* : show-ahead consumer port of the byte FIFO
//   overflow/err_count   : sticky drop flag, saturating error count
//   timeout         : one-cycle pulse when a frame stays busy too long
//   clr             : zeroes overflow and err_count
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 200,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic              rx_clk,
    input  logic              rx_rst_n,
    input  logic              ctrl_en,
    uart_rx_ctrl_if.slave     rx_if,
    input  logic              rd_en,
    output logic [BYTE_W-1:0] rd_data,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              overflow,
    output logic [7:0]        err_count,
    output logic              timeout,
    input  logic              clr
);
    localparam int BUSY_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int REC_W  = $clog2(RECOVER_CYCLES + 1);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    ctrl_state_e       state_q, state_d;
    logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
    logic [REC_W-1:0]  rec_cnt_q, rec_cnt_d;
    logic              rx_en_q, rx_en_d;
    logic              rx_start_q, rx_start_d;
    logic              timeout_q, timeout_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        err_count_q, err_count_d;
    logic              rx_err_q, rx_done_q;
    logic              err_rise, done_rise, err_inc, push, drop;

    assign err_rise  = rx_if.rx_err & ~rx_err_q;
    assign done_rise = rx_if.rx_done & ~rx_done_q;
    assign push      = done_rise & (state_q == ST_ARMED);
    // A pop on the same edge makes room, so only an unpopped full push drops.
    assign drop      = push & fifo_full & ~rd_en;

    always_comb begin
        state_d    = state_q;
        busy_cnt_d = '0;
        rec_cnt_d  = '0;
        timeout_d  = 1'b0;
        err_inc    = 1'b0;
        case (state_q)
            ST_OFF:  if (ctrl_en) state_d = ST_INIT;
            ST_INIT: state_d = ST_ARMED;
            ST_ARMED: begin
                if (err_rise) begin
                    err_inc = 1'b1;
                    state_d = ST_RECOVER;
                end else if (rx_if.rx_busy) begin
                    if (busy_cnt_q == BUSY_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = ST_RECOVER;
                    end else begin
                        busy_cnt_d = busy_cnt_q + 1'b1;
                    end
                end
            end
            ST_RECOVER: begin
                if (rec_cnt_q == REC_W'(RECOVER_CYCLES - 1)) state_d = ST_INIT;
                else rec_cnt_d = rec_cnt_q + 1'b1;
            end
            default: state_d = ST_OFF;
        endcase
        if (!ctrl_en) begin
            state_d    = ST_OFF;
            busy_cnt_d = '0;
            rec_cnt_d  = '0;
            timeout_d  = 1'b0;
        end
        // Outputs are decoded from the next state so they register in step with it.
        rx_en_d    = (state_d == ST_INIT) || (state_d == ST_ARMED);
        rx_start_d = (state_d == ST_ARMED);
        // clr wins over any same-cycle increment/drop.
        if (clr) begin
            err_count_d = '0;
            overflow_d  = 1'b0;
        end else begin
            err_count_d = err_inc ? sat_inc8(err_count_q) : err_count_q;
            overflow_d  = overflow_q | drop;
        end
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state_q     <= ST_OFF;
            busy_cnt_q  <= '0;
            rec_cnt_q   <= '0;
            rx_en_q     <= 1'b0;
            rx_start_q  <= 1'b0;
            timeout_q   <= 1'b0;
            overflow_q  <= 1'b0;
            err_count_q <= '0;
            rx_err_q    <= 1'b0;
            rx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_cnt_q  <= busy_cnt_d;
            rec_cnt_q   <= rec_cnt_d;
            rx_en_q     <= rx_en_d;
            rx_start_q  <= rx_start_d;
            timeout_q   <= timeout_d;
            overflow_q  <= overflow_d;
            err_count_q <= err_count_d;
            rx_err_q    <= rx_if.rx_err;
            rx_done_q   <= rx_if.rx_done;
        end
    end

    assign rx_if.rx_en    = rx_en_q;
    assign rx_if.rx_start = rx_start_q;
    assign timeout        = timeout_q;
    assign overflow       = overflow_q;
    assign err_count      = err_count_q;

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (rx_clk),
        .rst_n   (rx_rst_n),
        .push    (push),
        .wr_data (rx_if.rx_data),
        .pop     (rd_en),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;
    localparam int DEPTH   = 4;
    localparam int TMO     = 200;
    localparam int REC     = 2;

    logic       rx_clk = 1'b0;
    logic       rx_rst_n = 1'b0;
    logic       ctrl_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] rd_data;
    logic       fifo_empty, fifo_full, overflow, timeout;
    logic [4:0] fifo_count;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    uart_rx_ctrl_if rx_if ();

    uart_rx_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .RECOVER_CYCLES(REC)) dut (
        .rx_clk     (rx_clk),
        .rx_rst_n   (rx_rst_n),
        .ctrl_en    (ctrl_en),
        .rx_if      (rx_if.slave),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .err_count  (err_count),
        .timeout    (timeout),
        .clr        (clr)
    );

    always #5 rx_clk = ~rx_clk;

    task automatic tick();
        @(posedge rx_clk);
        #1;
    endtask

    // One-cycle rx_done pulse followed by a low cycle so each pulse is a fresh rise.
    task automatic send_byte(input logic [7:0] b);
        rx_if.rx_data = b;
        rx_if.rx_done = 1'b1;
        tick();
        rx_if.rx_done = 1'b0;
        tick();
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        checks++;
        if (rd_data !== exp) begin
            errors++;
            $display("FAIL %s: rd_data got %02h expected %02h", name, rd_data, exp);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rx_if.rx_data = 8'h00; rx_if.rx_done = 1'b0; rx_if.rx_busy = 1'b0; rx_if.rx_err = 1'b0;
        rx_rst_n = 1'b0;
        repeat (3) @(negedge rx_clk);
        checks++;
        if ({rx_if.rx_en, rx_if.rx_start, timeout, overflow, fifo_full, fifo_empty} !== 6'b000001
            || err_count !== 8'd0 || fifo_count !== 5'd0 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset: en=%b st=%b to=%b ovf=%b full=%b empty=%b ec=%0d cnt=%0d rd=%02h expected 0 0 0 0 0 1 0 0 00",
                     rx_if.rx_en, rx_if.rx_start, timeout, overflow, fifo_full, fifo_empty, err_count, fifo_count, rd_data);
        end
        rx_rst_n = 1'b1;
        tick();
        checks++;
        if (rx_if.rx_en !== 1'b0 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_off: rx_en got %b rd %02h expected 0 00", rx_if.rx_en, rd_data);
        end
    endtask

    task automatic test_arm();
        ctrl_en = 1'b1;
        tick();
        checks++;
        if ({rx_if.rx_en, rx_if.rx_start} !== 2'b10) begin
            errors++;
            $display("FAIL arm_init: en/start got %b%b expected 10", rx_if.rx_en, rx_if.rx_start);
        end
        repeat (2) begin
            tick();
            checks++;
            if ({rx_if.rx_en, rx_if.rx_start} !== 2'b11) begin
                errors++;
                $display("FAIL arm_armed: en/start got %b%b expected 11", rx_if.rx_en, rx_if.rx_start);
            end
        end
    endtask

    task automatic test_fifo_order();
        logic [7:0] seq [3] = '{8'hA5, 8'h3C, 8'hFF};
        foreach (seq[i]) send_byte(seq[i]);
        checks++;
        if (fifo_count !== 5'd3) begin
            errors++;
            $display("FAIL order_count: got %0d expected 3", fifo_count);
        end
        foreach (seq[i]) pop_expect("order_pop", seq[i]);
        checks++;
        if (fifo_empty !== 1'b1 || fifo_count !== 5'd0) begin
            errors++;
            $display("FAIL order_empty: empty %b count %0d expected 1 0", fifo_empty, fifo_count);
        end
        // A held rx_done pushes a single byte.
        rx_if.rx_data = 8'h5A;
        rx_if.rx_done = 1'b1;
        repeat (4) tick();
        rx_if.rx_done = 1'b0;
        tick();
        checks++;
        if (fifo_count !== 5'd1) begin
            errors++;
            $display("FAIL held_done: count got %0d expected 1", fifo_count);
        end
        pop_expect("held_done_pop", 8'h5A);
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i));
            if (i == 4) begin
                checks++;
                if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_full4: full %b ovf %b expected 1 0", fifo_full, overflow);
                end
            end
        end
        checks++;
        if (overflow !== 1'b1 || fifo_count !== 5'd4 || rd_data !== 8'h01) begin
            errors++;
            $display("FAIL ovf_drop: ovf %b count %0d head %02h expected 1 4 01", overflow, fifo_count, rd_data);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr: got %b expected 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] held;
        rx_if.rx_data = 8'h11;
        rx_if.rx_done = 1'b1;
        rd_en = 1'b1;
        tick();
        rx_if.rx_done = 1'b0;
        rd_en = 1'b0;
        tick();
        checks++;
        if (fifo_count !== 5'd4 || overflow !== 1'b0 || fifo_full !== 1'b1) begin
            errors++;
            $display("FAIL full_pushpop: count %0d ovf %b full %b expected 4 0 1", fifo_count, overflow, fifo_full);
        end
        pop_expect("fpp_pop", 8'h02);
        pop_expect("fpp_pop", 8'h03);
        pop_expect("fpp_pop", 8'h04);
        pop_expect("fpp_tail", 8'h11);
        held = rd_data;
        rd_en = 1'b1;
        repeat (2) tick();
        rd_en = 1'b0;
        checks++;
        if (fifo_count !== 5'd0 || fifo_empty !== 1'b1 || rd_data !== held) begin
            errors++;
            $display("FAIL empty_pop: count %0d empty %b rd %02h expected 0 1 %02h", fifo_count, fifo_empty, rd_data, held);
        end
    endtask

    // Expected en/start per cycle after the trigger edge: REC cycles off, 1 INIT, then ARMED.
    task automatic check_recovery(input string name);
        for (int c = 0; c < REC + 2; c++) begin
            logic [1:0] exp;
            exp = (c < REC) ? 2'b00 : (c == REC) ? 2'b10 : 2'b11;
            checks++;
            if ({rx_if.rx_en, rx_if.rx_start} !== exp) begin
                errors++;
                $display("FAIL %s: cycle %0d en/start got %b%b expected %b", name, c, rx_if.rx_en, rx_if.rx_start, exp);
            end
            tick();
        end
    endtask

    task automatic test_error_recover();
        rx_if.rx_err = 1'b1;
        tick();
        rx_if.rx_err = 1'b0;
        checks++;
        if (err_count !== 8'd1) begin
            errors++;
            $display("FAIL err_count: got %0d expected 1", err_count);
        end
        check_recovery("err_recover");
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (err_count !== 8'd0) begin
            errors++;
            $display("FAIL err_clr: got %0d expected 0", err_count);
        end
    endtask

    task automatic test_timeout();
        int seen = 0;
        rx_if.rx_busy = 1'b1;
        for (int k = 1; k <= TMO + 50 && seen == 0; k++) begin
            tick();
            if (timeout === 1'b1) seen = k;
        end
        rx_if.rx_busy = 1'b0;
        checks++;
        if (seen != TMO) begin
            errors++;
            $display("FAIL timeout_at: pulse after %0d busy cycles expected %0d", seen, TMO);
        end
        // The pulse cycle is the first RECOVER cycle.
        for (int c = 0; c < REC + 2; c++) begin
            logic [1:0] exp;
            exp = (c < REC) ? 2'b00 : (c == REC) ? 2'b10 : 2'b11;
            checks++;
            if ({rx_if.rx_en, rx_if.rx_start} !== exp || timeout !== (c == 0)) begin
                errors++;
                $display("FAIL timeout_seq: cycle %0d en/start %b%b to %b expected %b %b",
                         c, rx_if.rx_en, rx_if.rx_start, timeout, exp, (c == 0));
            end
            tick();
        end
        checks++;
        if (err_count !== 8'd0) begin
            errors++;
            $display("FAIL timeout_errcnt: got %0d expected 0", err_count);
        end
    endtask

    task automatic test_random();
        logic [7:0] q [$];
        logic       m_ovf = 1'b0;
        logic       prev_done = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic d, r;
            logic [7:0] b;
            d = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 3) == 0);
            b = 8'($urandom);
            rx_if.rx_done = d;
            rx_if.rx_data = b;
            rd_en = r;
            if (r && q.size() > 0) begin
                void'(q.pop_front());
                if (d && !prev_done) q.push_back(b);
            end else if (d && !prev_done) begin
                if (q.size() < DEPTH) q.push_back(b);
                else m_ovf = 1'b1;
            end
            prev_done = d;
            tick();
            checks++;
            if (fifo_count !== 5'(q.size()) || overflow !== m_ovf ||
                (q.size() > 0 && rd_data !== q[0])) begin
                errors++;
                $display("FAIL random: step %0d count %0d ovf %b rd %02h expected %0d %b %02h",
                         n, fifo_count, overflow, rd_data, q.size(), m_ovf, (q.size() > 0) ? q[0] : 8'h00);
            end
        end
        rx_if.rx_done = 1'b0;
        rd_en = 1'b0;
        tick();
        // Disabling drops to OFF next edge but keeps buffered bytes.
        ctrl_en = 1'b0;
        tick();
        checks++;
        if (rx_if.rx_en !== 1'b0 || rx_if.rx_start !== 1'b0 || fifo_count !== 5'(q.size())) begin
            errors++;
            $display("FAIL disable_keep: en %b start %b count %0d expected 0 0 %0d",
                     rx_if.rx_en, rx_if.rx_start, fifo_count, q.size());
        end
    endtask

    task automatic test_reset_midframe();
        rx_if.rx_done = 1'b1;
        rx_if.rx_data = 8'h77;
        #2 rx_rst_n = 1'b0;
        #3;
        checks++;
        if (fifo_count !== 5'd0 || rx_if.rx_en !== 1'b0 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: count %0d en %b rd %02h expected 0 0 00", fifo_count, rx_if.rx_en, rd_data);
        end
        @(negedge rx_clk);
        rx_rst_n = 1'b1;
        ctrl_en = 1'b1;
        repeat (4) tick();
        checks++;
        if (fifo_count !== 5'd0 || rx_if.rx_start !== 1'b1) begin
            errors++;
            $display("FAIL midframe: count %0d start %b expected 0 1", fifo_count, rx_if.rx_start);
        end
        rx_if.rx_done = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_arm();
        test_fifo_order();
        test_overflow();
        test_full_push_pop();
        test_error_recover();
        test_timeout();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        test_random();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
